// File: rtl/instruction_fetch_unit.sv
// IF stage of the 5-stage RISC-V pipeline: owns the PC, issues I-memory reads and handles EX redirects.
// Optional performance counters are enabled by defining IFU_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
`ifdef IFU_PERF_COUNTERS_EN
    output logic [31:0] FETCH_COUNT,
    output logic [31:0] MISS_CYCLES,
    output logic [31:0] FLUSH_COUNT,
`endif
    input  logic        reset,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_INCREMENT4,
    output logic        BUSY_WAIT
);

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] pending_target_r, pending_target_s;
    logic [31:0] aligned_target_s;
    logic        fetch_hit_s;
    logic        flush_s;
    logic        miss_s;

    assign aligned_target_s = {BRANCH_TARGET[31:2], 2'b00};
    assign IMEM_ADDRESS     = pc_r;
    assign PC_OUT           = pc_r;
    assign PC_INCREMENT4    = pc_r + 32'd4;

    // State, PC and pending redirect registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r          <= ST_RST;
            pc_r             <= RESET_PC;
            pending_target_r <= 32'h0000_0000;
        end else begin
            state_r          <= state_s;
            pc_r             <= pc_s;
            pending_target_r <= pending_target_s;
        end
    end

    // Next-state, next-PC and IF/ID-facing outputs.
    always_comb begin
        state_s          = state_r;
        pc_s             = pc_r;
        pending_target_s = pending_target_r;
        IMEM_READ        = 1'b1;
        BUSY_WAIT        = 1'b1;
        INSTRUCTION      = NOP_INSTR;
        fetch_hit_s      = 1'b0;
        flush_s          = 1'b0;
        miss_s           = 1'b0;
        case (state_r)
            ST_RST: begin
                IMEM_READ = 1'b0;
                state_s   = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                miss_s = IMEM_BUSYWAIT;
                // Branch outranks STALL: it belongs to an older instruction.
                if (BRANCH_TAKEN && !IMEM_BUSYWAIT) begin
                    pc_s      = aligned_target_s;
                    BUSY_WAIT = 1'b0;
                    flush_s   = 1'b1;
                end else if (BRANCH_TAKEN) begin
                    pending_target_s = aligned_target_s;
                    state_s          = ST_DRAIN;
                    flush_s          = 1'b1;
                end else if (STALL) begin
                    pc_s = pc_r;
                end else if (!IMEM_BUSYWAIT) begin
                    pc_s        = pc_r + 32'd4;
                    INSTRUCTION = IMEM_READDATA;
                    BUSY_WAIT   = 1'b0;
                    fetch_hit_s = 1'b1;
                end else begin
                    pc_s = pc_r;
                end
            end
            ST_DRAIN: begin
                miss_s  = IMEM_BUSYWAIT;
                flush_s = BRANCH_TAKEN;
                // The old request stays on the bus until memory completes; its data is dropped.
                if (BRANCH_TAKEN) begin
                    pending_target_s = aligned_target_s;
                end else begin
                    pending_target_s = pending_target_r;
                end
                if (!IMEM_BUSYWAIT) begin
                    pc_s    = BRANCH_TAKEN ? aligned_target_s : pending_target_r;
                    state_s = ST_ACTIVE;
                end else begin
                    pc_s = pc_r;
                end
            end
            default: begin
                IMEM_READ = 1'b0;
                state_s   = ST_RST;
            end
        endcase
    end

`ifdef IFU_PERF_COUNTERS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // Saturating performance counters.
    always_ff @(posedge CLK) begin
        if (reset) begin
            FETCH_COUNT <= 32'h0000_0000;
            MISS_CYCLES <= 32'h0000_0000;
            FLUSH_COUNT <= 32'h0000_0000;
        end else begin
            if (fetch_hit_s) FETCH_COUNT <= sat_inc(FETCH_COUNT);
            if (miss_s)      MISS_CYCLES <= sat_inc(MISS_CYCLES);
            if (flush_s)     FLUSH_COUNT <= sat_inc(FLUSH_COUNT);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected fetches queued by each scenario, compared by a monitor.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        reset;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        STALL;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_OUT;
    logic [31:0] PC_INCREMENT4;
    logic        BUSY_WAIT;
`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] FETCH_COUNT, MISS_CYCLES, FLUSH_COUNT;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_fetch = 0;
    int exp_flush = 0;
    int exp_miss  = 0;
    logic [31:0] exp_q[$];

    instruction_fetch_unit dut (
        .CLK(CLK),
`ifdef IFU_PERF_COUNTERS_EN
        .FETCH_COUNT(FETCH_COUNT),
        .MISS_CYCLES(MISS_CYCLES),
        .FLUSH_COUNT(FLUSH_COUNT),
`endif
        .reset(reset),
        .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .STALL(STALL),
        .IMEM_READ(IMEM_READ),
        .IMEM_ADDRESS(IMEM_ADDRESS),
        .IMEM_READDATA(IMEM_READDATA),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .INSTRUCTION(INSTRUCTION),
        .PC_OUT(PC_OUT),
        .PC_INCREMENT4(PC_INCREMENT4),
        .BUSY_WAIT(BUSY_WAIT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    assign IMEM_READDATA = mem_word(IMEM_ADDRESS);

    // Monitor: every instruction captured by IF/ID must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (reset === 1'b0 && BUSY_WAIT === 1'b0 && INSTRUCTION !== NOP) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_fetch: got pc=%h instr=%h, required no fetch", PC_OUT, INSTRUCTION);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                n_fetch++;
                if (PC_OUT !== e || INSTRUCTION !== mem_word(e)) begin
                    n_fail++;
                    $display("FAIL fetch: got pc=%h instr=%h, required pc=%h instr=%h",
                             PC_OUT, INSTRUCTION, e, mem_word(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic bt, input logic [31:0] tgt, input logic st, input logic busy);
        BRANCH_TAKEN  = bt;
        BRANCH_TARGET = tgt;
        STALL         = st;
        IMEM_BUSYWAIT = busy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if (IMEM_READ !== 1'b0 || BUSY_WAIT !== 1'b1 || INSTRUCTION !== NOP || IMEM_ADDRESS !== 32'h0 ||
            PC_OUT !== 32'h0 || PC_INCREMENT4 !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_state: got read=%b bw=%b instr=%h addr=%h pc=%h pc4=%h, required 0 1 %h 0 0 4",
                     IMEM_READ, BUSY_WAIT, INSTRUCTION, IMEM_ADDRESS, PC_OUT, PC_INCREMENT4, NOP);
        end
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0);
            exp_q.push_back(32'(i * 4));
            n_tests++;
            if (IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 32'(i * 4) || BUSY_WAIT !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_hit: got read=%b addr=%h bw=%b, required 1 %h 0",
                         IMEM_READ, IMEM_ADDRESS, BUSY_WAIT, 32'(i * 4));
            end
            tick();
        end
    endtask

    task automatic test_miss();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b1);
            exp_miss++;
            n_tests++;
            if (BUSY_WAIT !== 1'b1 || PC_OUT !== 32'h10 || INSTRUCTION !== NOP) begin
                n_fail++;
                $display("FAIL miss_hold: got bw=%b pc=%h instr=%h, required 1 00000010 %h",
                         BUSY_WAIT, PC_OUT, INSTRUCTION, NOP);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0);
            exp_q.push_back(32'h10 + 32'(i * 4));
            n_tests++;
            if (PC_OUT !== 32'h10 + 32'(i * 4) || BUSY_WAIT !== 1'b0) begin
                n_fail++;
                $display("FAIL miss_resume: got pc=%h bw=%b, required %h 0", PC_OUT, BUSY_WAIT, 32'h10 + 32'(i * 4));
            end
            tick();
        end
    endtask

    task automatic redirect_hit(input logic [31:0] tgt, input logic st, input logic [31:0] want);
        set_in(1'b1, tgt, st, 1'b0);
        exp_flush++;
        n_tests++;
        if (INSTRUCTION !== NOP || BUSY_WAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_bubble: got instr=%h bw=%b, required %h 0", INSTRUCTION, BUSY_WAIT, NOP);
        end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (IMEM_ADDRESS !== want || IMEM_READ !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_addr: got addr=%h read=%b, required %h 1", IMEM_ADDRESS, IMEM_READ, want);
        end
    endtask

    task automatic test_redirect_hit();
        redirect_hit(32'h100, 1'b0, 32'h100);
        exp_q.push_back(32'h100);
        tick();
        redirect_hit(32'h42, 1'b0, 32'h40);
    endtask

    task automatic test_redirect_miss();
        set_in(1'b1, 32'h200, 1'b0, 1'b1);
        exp_flush++;
        exp_miss++;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 32'h0, 1'b0, (i < 2) ? 1'b1 : 1'b0);
            if (i < 2) exp_miss++;
            n_tests++;
            if (IMEM_ADDRESS !== 32'h40 || IMEM_READ !== 1'b1 || BUSY_WAIT !== 1'b1 || INSTRUCTION !== NOP) begin
                n_fail++;
                $display("FAIL drain_hold: got addr=%h read=%b bw=%b instr=%h, required 00000040 1 1 %h",
                         IMEM_ADDRESS, IMEM_READ, BUSY_WAIT, INSTRUCTION, NOP);
            end
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (IMEM_ADDRESS !== 32'h200) begin
            n_fail++;
            $display("FAIL drain_target: got addr=%h, required 00000200", IMEM_ADDRESS);
        end
        // Second redirect arrives while draining: the youngest target must win.
        set_in(1'b1, 32'h500, 1'b0, 1'b1);
        exp_flush++;
        exp_miss++;
        tick();
        set_in(1'b1, 32'h31, 1'b0, 1'b1);
        exp_flush++;
        exp_miss++;
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        n_tests++;
        if (IMEM_ADDRESS !== 32'h30) begin
            n_fail++;
            $display("FAIL youngest_redirect: got addr=%h, required 00000030", IMEM_ADDRESS);
        end
    endtask

    task automatic test_stall_vs_branch();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 32'h0, 1'b1, 1'b0);
            n_tests++;
            if (PC_OUT !== 32'h30 || BUSY_WAIT !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold: got pc=%h bw=%b, required 00000030 1", PC_OUT, BUSY_WAIT);
            end
            tick();
        end
        redirect_hit(32'h80, 1'b1, 32'h80);
        exp_q.push_back(32'h80);
        tick();
        redirect_hit(32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        n_tests++;
        if (PC_OUT !== 32'h0 || PC_INCREMENT4 !== 32'h4) begin
            n_fail++;
            $display("FAIL pc_wrap: got pc=%h pc4=%h, required 00000000 00000004", PC_OUT, PC_INCREMENT4);
        end
        redirect_hit(32'h50, 1'b0, 32'h50);
    endtask

    task automatic test_reset_mid_miss();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (BUSY_WAIT !== 1'b1 || PC_OUT !== 32'h50) begin
            n_fail++;
            $display("FAIL pre_reset_miss: got bw=%b pc=%h, required 1 00000050", BUSY_WAIT, PC_OUT);
        end
`ifdef IFU_PERF_COUNTERS_EN
        n_tests++;
        if (FETCH_COUNT !== 32'(n_fetch) || MISS_CYCLES !== 32'(exp_miss) || FLUSH_COUNT !== 32'(exp_flush)) begin
            n_fail++;
            $display("FAIL perf_counts: got fetch=%0d miss=%0d flush=%0d, required %0d %0d %0d",
                     FETCH_COUNT, MISS_CYCLES, FLUSH_COUNT, n_fetch, exp_miss, exp_flush);
        end
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if (IMEM_READ !== 1'b0 || PC_OUT !== 32'h0 || BUSY_WAIT !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_miss: got read=%b pc=%h bw=%b, required 0 00000000 1", IMEM_READ, PC_OUT, BUSY_WAIT);
        end
`ifdef IFU_PERF_COUNTERS_EN
        n_tests++;
        if (FETCH_COUNT !== 32'h0 || MISS_CYCLES !== 32'h0 || FLUSH_COUNT !== 32'h0) begin
            n_fail++;
            $display("FAIL perf_reset: got %h %h %h, required all zero", FETCH_COUNT, MISS_CYCLES, FLUSH_COUNT);
        end
`endif
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        exp_q.push_back(32'h0);
        n_tests++;
        if (IMEM_ADDRESS !== 32'h0 || IMEM_READ !== 1'b1 || BUSY_WAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_after_reset: got addr=%h read=%b bw=%b, required 0 1 0", IMEM_ADDRESS, IMEM_READ, BUSY_WAIT);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_miss();
        test_redirect_hit();
        test_redirect_miss();
        test_stall_vs_branch();
        test_reset_mid_miss();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending fetches, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the 5-stage RISC-V pipeline.
- Owns the PC and issues read requests to instruction memory/I-cache.
- Handles branch/jump redirects from EX, including redirects that arrive during an outstanding miss.
- Drives the instruction, PC+4 and hold signal that the downstream IF/ID pipeline register captures.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction emitted on flush/discard (addi x0,x0,0)

Ports:
CLK  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
BRANCH_TAKEN  input  1  one-cycle redirect pulse from EX
BRANCH_TARGET  input  32  redirect address; valid when BRANCH_TAKEN=1
STALL  input  1  hazard-unit hold (load-use); freezes PC
IMEM_READ  output  1  read request to instruction memory
IMEM_ADDRESS  output  32  fetch address
IMEM_READDATA  input  32  instruction word; valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
IMEM_BUSYWAIT  input  1  memory not ready
INSTRUCTION  output  32  instruction to IF/ID register
PC_OUT  output  32  address of INSTRUCTION
PC_INCREMENT4  output  32  PC_OUT+4, to IF/ID register
BUSY_WAIT  output  1  IF/ID hold; 1 = do not capture

Behaviour:
- Clock is CLK. reset is synchronous and active-high, sampled on the CLK rising edge, and overrides everything.
- Registers: PC (32), PENDING_TARGET (32), state (2 bits).
- FSM states:
  - RST: entered on reset. IMEM_READ=0, BUSY_WAIT=1, INSTRUCTION=NOP_INSTR. Next state ACTIVE unconditionally.
  - ACTIVE: IMEM_READ=1, IMEM_ADDRESS=PC.
  - DRAIN: IMEM_READ=1, IMEM_ADDRESS=PC (old address held). Returning data is discarded.
- Reset values:
  - PC=RESET_PC, PENDING_TARGET=0, state=RST.
  - Outputs in RST: IMEM_READ=0, IMEM_ADDRESS=RESET_PC, INSTRUCTION=NOP_INSTR, PC_OUT=RESET_PC, PC_INCREMENT4=RESET_PC+4, BUSY_WAIT=1.
- Fetch complete ("hit cycle") = state ACTIVE and IMEM_BUSYWAIT=0.
- ACTIVE transitions, evaluated in priority order each edge:
  1. BRANCH_TAKEN and IMEM_BUSYWAIT=0: PC<=BRANCH_TARGET. Stay ACTIVE. This cycle INSTRUCTION=NOP_INSTR and BUSY_WAIT=0, so a bubble is written into IF/ID.
  2. BRANCH_TAKEN and IMEM_BUSYWAIT=1: PENDING_TARGET<=BRANCH_TARGET, go to DRAIN. BUSY_WAIT=1.
  3. STALL=1: PC holds, BUSY_WAIT=1. The request is repeated next cycle.
  4. Hit cycle: PC<=PC+4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal). INSTRUCTION=IMEM_READDATA, BUSY_WAIT=0.
  5. Miss (IMEM_BUSYWAIT=1): PC holds, BUSY_WAIT=1, INSTRUCTION=NOP_INSTR.
- DRAIN transitions:
  - BUSY_WAIT=1 and INSTRUCTION=NOP_INSTR throughout.
  - When IMEM_BUSYWAIT=0: PC<=PENDING_TARGET, go to ACTIVE.
  - A further BRANCH_TAKEN in DRAIN overwrites PENDING_TARGET (youngest redirect wins).
- Latency:
  - Hit: one instruction per cycle.
  - First instruction after reset deassertion is presented in cycle 2 (RST cycle, then ACTIVE).
  - Redirect on hit: target address driven on IMEM_ADDRESS the next cycle.
- Address rules:
  - PC[1:0] is always 0.
  - BRANCH_TARGET[1:0] is forced to 0 when loaded (no misalignment trap in this stage).
- Simultaneous events:
  - BRANCH_TAKEN beats STALL, since the branch is older than the stalled instruction.
  - reset beats all.
  - reset during a miss or DRAIN drops IMEM_READ for one cycle. Memory abandons the transaction when IMEM_READ falls.
- Combinational outputs: PC_OUT=PC and PC_INCREMENT4=PC+4 in all states.

Optional Feature:
- Macro: IFU_PERF_COUNTERS_EN.
- When defined, the block adds three 32-bit output ports:
  - FETCH_COUNT: increments on every hit cycle with BUSY_WAIT=0 and a non-flushed instruction.
  - MISS_CYCLES: increments on every cycle in ACTIVE or DRAIN with IMEM_BUSYWAIT=1.
  - FLUSH_COUNT: increments on each accepted BRANCH_TAKEN.
  - All three reset to 0 on reset and saturate at 32'hFFFF_FFFF.
- When not defined, these ports and registers do not exist and the behaviour is otherwise identical.

Test Plan:
- Sequential hits: reset with RESET_PC=0, IMEM_BUSYWAIT=0 always -> IMEM_ADDRESS 0,4,8,12 on consecutive cycles; INSTRUCTION follows the memory words; BUSY_WAIT=0 from cycle 2.
- Miss: 3-cycle IMEM_BUSYWAIT at address 0x10 -> BUSY_WAIT=1 and PC=0x10 held for 3 cycles; the instruction is delivered on cycle 4, then PC=0x14.
- Redirect on hit: BRANCH_TAKEN with target 0x100 while PC=0x20 hits -> INSTRUCTION=0x00000013 that cycle; next IMEM_ADDRESS=0x100.
- Redirect during miss: miss at 0x40, BRANCH_TAKEN with target 0x200 in miss cycle 1, busy for 2 more cycles -> data from 0x40 discarded, NOP_INSTR held; next request at 0x200.
- Stall versus branch: STALL=1 at PC=0x30 for 2 cycles -> PC held; STALL and BRANCH_TAKEN (0x80) asserted together -> PC=0x80 next.
- Reset mid-miss: reset asserted during a miss at 0x50 -> next cycle IMEM_READ=0 and PC=0; fetch resumes at 0. With IFU_PERF_COUNTERS_EN defined, all counters read 0.
